// File: rtl/csa_accum_ctrl.sv
// Carry-save batch accumulator: sums a stream of operands in carry-save
// form, then resolves S+C in K-bit chunks before presenting the result.
`timescale 1ns/1ps
module csa_accum_ctrl #(
    parameter int N  = 32,
    parameter int K  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic [CW-1:0] out_count,
    output logic          busy
);

    localparam int NC = N / K;
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        OUTPUT
    } state_t;

    state_t        state;
    logic [N-1:0]  s_q;
    logic [N-1:0]  c_q;
    logic [N-1:0]  r_q;
    logic [CW-1:0] cnt_q;
    logic          cy_q;
    logic [IW-1:0] idx_q;
    logic          rdy_q;
    logic          vld_q;

    logic [N-1:0]  maj;
    logic [K:0]    csum;

    assign maj  = (s_q & c_q) | (s_q & in_data) | (c_q & in_data);

    // One chunk of the final carry-propagate add per cycle
    assign csum = {1'b0, s_q[idx_q*K +: K]}
                + {1'b0, c_q[idx_q*K +: K]}
                + {{K{1'b0}}, cy_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            s_q   <= '0;
            c_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
            cy_q  <= 1'b0;
            idx_q <= '0;
            rdy_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    rdy_q <= 1'b1;
                    if (in_valid && rdy_q) begin
                        s_q   <= s_q ^ c_q ^ in_data;
                        c_q   <= maj << 1;
                        cnt_q <= cnt_q + CW'(1);
                        if (in_last) begin
                            state <= RESOLVE;
                            rdy_q <= 1'b0;
                            idx_q <= '0;
                            cy_q  <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                RESOLVE: begin
                    r_q[idx_q*K +: K] <= csum[K-1:0];
                    cy_q  <= csum[K];
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(NC - 1)) begin
                        state <= OUTPUT;
                        vld_q <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state <= IDLE;
                        vld_q <= 1'b0;
                        rdy_q <= 1'b1;
                        s_q   <= '0;
                        c_q   <= '0;
                        r_q   <= '0;
                        cnt_q <= '0;
                        cy_q  <= 1'b0;
                        idx_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_sum   = vld_q ? r_q : '0;
    assign out_count = vld_q ? cnt_q : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Bench for csa_accum_ctrl: directed scenarios plus a randomized
// scoreboard run over many batches with random handshake timing.
`timescale 1ns/1ps
module tb_csa_accum_ctrl;

    localparam int N  = 32;
    localparam int K  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_sum;
    logic [CW-1:0] out_count;
    logic          busy;

    typedef struct packed {
        logic [N-1:0]  sum;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    logic [N-1:0]  m_sum = '0;
    logic [CW-1:0] m_cnt = '0;
    int            vectors = 0;
    int            miscompares = 0;

    csa_accum_ctrl #(.N(N), .K(K), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic push_model(input logic [N-1:0] d, input logic last);
        exp_t e;
        m_sum = m_sum + d;
        m_cnt = m_cnt + 1'b1;
        if (last) begin
            e.sum = m_sum;
            e.cnt = m_cnt;
            sb.push_back(e);
            m_sum = '0;
            m_cnt = '0;
        end
    endtask

    // Present one beat, hold until accepted, then idle for gap cycles
    task automatic put_beat(input logic [N-1:0] d, input logic last,
                            input int gap);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        t = 0;
        while (in_ready !== 1'b1 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL put_beat_timeout in_ready=%b required 1", in_ready);
        end else begin
            @(posedge clk);
            push_model(d, last);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        if (out_valid !== 1'b1) cyc = -1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_sum !== '0
            || out_count !== '0) begin
            miscompares++;
            $display("FAIL reset_state rdy/vld/busy=%b sum=%h cnt=%h required 000 0 0",
                     {in_ready, out_valid, busy}, out_sum, out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release in_ready=%b busy=%b required 1 0",
                     in_ready, busy);
        end
    endtask

    task automatic test_single_beat();
        int   cyc;
        exp_t e;
        put_beat(32'd5, 1'b1, 0);
        wait_out(cyc);
        vectors++;
        if (cyc != N / K) begin
            miscompares++;
            $display("FAIL single_latency cycles=%0d required %0d", cyc, N / K);
        end
        e = sb.pop_front();
        vectors++;
        if (out_sum !== e.sum || out_sum !== 32'd5 || out_count !== 16'd1) begin
            miscompares++;
            $display("FAIL single_result sum=%h cnt=%0d required 00000005 1",
                     out_sum, out_count);
        end
        release_out();
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0
            || out_sum !== '0) begin
            miscompares++;
            $display("FAIL single_return rdy=%b busy=%b vld=%b sum=%h required 1 0 0 0",
                     in_ready, busy, out_valid, out_sum);
        end
    endtask

    task automatic test_wrap();
        int   cyc;
        exp_t e;
        put_beat(32'hFFFF_FFFF, 1'b0, 0);
        put_beat(32'h0000_0001, 1'b1, 0);
        wait_out(cyc);
        e = sb.pop_front();
        vectors++;
        if (cyc < 0 || out_sum !== e.sum || out_sum !== 32'h0
            || out_count !== 16'd2) begin
            miscompares++;
            $display("FAIL wrap_result vld=%b sum=%h cnt=%0d required 00000000 2",
                     out_valid, out_sum, out_count);
        end
        release_out();
    endtask

    task automatic test_gaps();
        int   cyc;
        exp_t e;
        put_beat(32'h8000_0000, 1'b0, 3);
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_hold busy=%b rdy=%b vld=%b required 1 1 0",
                     busy, in_ready, out_valid);
        end
        put_beat(32'h8000_0000, 1'b0, 2);
        put_beat(32'h8000_0000, 1'b1, 0);
        wait_out(cyc);
        e = sb.pop_front();
        vectors++;
        if (cyc < 0 || out_sum !== e.sum || out_sum !== 32'h8000_0000
            || out_count !== 16'd3) begin
            miscompares++;
            $display("FAIL gaps_result sum=%h cnt=%0d required 80000000 3",
                     out_sum, out_count);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int   cyc;
        exp_t e;
        put_beat(32'd10, 1'b0, 0);
        put_beat(32'd20, 1'b1, 0);
        wait_out(cyc);
        e = sb.pop_front();
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_sum !== 32'd30 || out_sum !== e.sum
                || out_count !== 16'd2 || in_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] vld=%b sum=%h cnt=%0d rdy=%b busy=%b required 1 1e 2 0 1",
                         i, out_valid, out_sum, out_count, in_ready, busy);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        release_out();
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0
            || out_count !== '0) begin
            miscompares++;
            $display("FAIL bp_release rdy=%b busy=%b vld=%b cnt=%0d required 1 0 0 0",
                     in_ready, busy, out_valid, out_count);
        end
    endtask

    task automatic test_reset_mid_resolve();
        int   cyc;
        exp_t e;
        put_beat(32'd9, 1'b1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_sum !== '0
            || out_count !== '0) begin
            miscompares++;
            $display("FAIL mid_reset rdy/vld/busy=%b sum=%h cnt=%h required 000 0 0",
                     {in_ready, out_valid, busy}, out_sum, out_count);
        end
        sb.delete();
        m_sum = '0;
        m_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        put_beat(32'd3, 1'b0, 0);
        put_beat(32'd4, 1'b1, 0);
        wait_out(cyc);
        e = sb.pop_front();
        vectors++;
        if (cyc != N / K || out_sum !== e.sum || out_sum !== 32'd7
            || out_count !== 16'd2) begin
            miscompares++;
            $display("FAIL post_reset_batch cyc=%0d sum=%h cnt=%0d required 4 7 2",
                     cyc, out_sum, out_count);
        end
        release_out();
    endtask

    task automatic test_stress();
        int            sent;
        int            got;
        int            nb;
        int            bi;
        int            cyc;
        logic [N-1:0]  cd;
        logic          in_fire;
        logic          out_fire;
        exp_t          e;
        sent = 0;
        got  = 0;
        cyc  = 0;
        nb   = $urandom_range(1, 20);
        bi   = 0;
        cd   = $urandom;
        while (got < 1000 && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 1) == 1);
            if (sent < 1000) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = cd;
                in_last  = (bi == nb - 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                got++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL stress_unexpected sum=%h cnt=%0d required no result",
                             out_sum, out_count);
                end else begin
                    e = sb.pop_front();
                    if (out_sum !== e.sum || out_count !== e.cnt) begin
                        miscompares++;
                        $display("FAIL stress_batch[%0d] sum=%h cnt=%0d required %h %0d",
                                 got, out_sum, out_count, e.sum, e.cnt);
                    end
                end
            end
            @(posedge clk);
            if (in_fire) begin
                push_model(cd, bi == nb - 1);
                if (bi == nb - 1) begin
                    sent++;
                    nb = $urandom_range(1, 20);
                    bi = 0;
                end else begin
                    bi++;
                end
                cd = $urandom;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (got != 1000 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL stress_completion results=%0d pending=%0d required 1000 0",
                     got, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_wrap();
        test_gaps();
        test_backpressure();
        test_reset_mid_resolve();
        test_stress();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
